iir_coeff_loader: RTL and testbench

- Host-side writer for the coefficient inputs of the 3-section cascaded IIR filter.
- Receives a 15-word coefficient frame over a valid/ready stream and collects it in a shadow bank.
- On a well-formed frame, commits the shadow bank atomically to the active bank that drives the filter, so the filter never sees a partially updated set.
- Also holds a sticky capture of the filter's combined overflow flag for the host.

---
 rtl/iir_pkg.sv | 33 +++
 rtl/iir_coeff_loader.sv | 188 ++++++++++++++++++
 tb/tb_iir_coeff_loader.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/iir_pkg.sv
// Shared definitions for the cascaded IIR filter coefficient path.
//
// Contents:
//   NUM_SECTIONS, COEFFS_PER_SECTION, NUM_COEFFS : bank geometry
//   B0, B1, B2, A1, A2                           : coefficient index within a section
//   loader_state_e                               : coefficient loader FSM states
//   unity_word()                                 : fixed-point 1.0 for a given fraction width
package iir_pkg;

  localparam int NUM_SECTIONS       = 3;
  localparam int COEFFS_PER_SECTION = 5;
  localparam int NUM_COEFFS         = NUM_SECTIONS * COEFFS_PER_SECTION;

  // Position of each coefficient inside one biquad section.
  localparam int B0 = 0;
  localparam int B1 = 1;
  localparam int B2 = 2;
  localparam int A1 = 3;
  localparam int A2 = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } loader_state_e;

  // Fixed-point representation of 1.0 with 'shift' fractional bits.
  // Returned wide so callers can truncate to their own word width.
  function automatic logic [63:0] unity_word(input int shift);
    return 64'd1 << shift;
  endfunction

endpackage

// File: rtl/iir_coeff_loader.sv
// Host-side coefficient writer for the 3-section cascaded IIR filter.
//
// Collects a 15-word coefficient frame from a valid/ready stream into a
// shadow bank, then swaps the whole frame into the active bank in a single
// clock edge so the filter never sees a mix of old and new coefficients.
// Also keeps a sticky copy of the filter's overflow flag for the host.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   s_valid/s_ready   : coefficient stream handshake
//   s_data, s_last    : coefficient word, final-word marker
//   abort             : drop the frame in progress
//   coeff_flat        : active bank, word k at [k*COEFF_WIDTH +: COEFF_WIDTH]
//   commit_pulse      : one cycle, first cycle showing the new active bank
//   frame_err         : one cycle, malformed frame was rejected
//   commit_count      : successful commits, wraps at 256
//   overflow_any      : combined filter overflow
//   ovf_clr           : clear request for the sticky flag
//   ovf_sticky        : latched overflow
module iir_coeff_loader
  import iir_pkg::*;
#(
  parameter int COEFF_WIDTH = 32,
  parameter int SCALE_SHIFT = 20
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [COEFF_WIDTH-1:0]            s_data,
  input  logic                              s_last,
  input  logic                              abort,
  output logic [NUM_COEFFS*COEFF_WIDTH-1:0] coeff_flat,
  output logic                              commit_pulse,
  output logic                              frame_err,
  output logic [7:0]                        commit_count,
  input  logic                              overflow_any,
  input  logic                              ovf_clr,
  output logic                              ovf_sticky
);

  localparam logic [COEFF_WIDTH-1:0] UNITY    = COEFF_WIDTH'(unity_word(SCALE_SHIFT));
  localparam logic [3:0]             LAST_IDX = 4'(NUM_COEFFS - 1);

  loader_state_e          state_q, state_d;
  logic [3:0]             idx_q, idx_d;
  logic                   commitPulse_q, commitPulse_d;
  logic                   frameErr_q, frameErr_d;
  logic [7:0]             commitCount_q;
  logic                   ovf_q, ovf_d;
  logic                   shadowWe;
  logic                   activeLoad;
  logic                   handshake;

  // The final word goes straight from s_data into the active bank, so the
  // shadow only ever needs to hold the first NUM_COEFFS-1 words.
  logic [COEFF_WIDTH-1:0] shadow_q [NUM_COEFFS-1];
  logic [COEFF_WIDTH-1:0] active_q [NUM_COEFFS];

  assign s_ready   = (state_q != COMMIT);
  assign handshake = s_valid && s_ready;

  // Frame sequencing. abort is checked before the handshake so a word
  // presented alongside it is dropped rather than stored.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    commitPulse_d = 1'b0;
    frameErr_d    = 1'b0;
    shadowWe      = 1'b0;
    activeLoad    = 1'b0;
    case (state_q)
      IDLE: begin
        if (abort) begin
          idx_d = 4'd0;
        end else if (handshake) begin
          shadowWe = 1'b1;
          if (s_last) begin
            frameErr_d = 1'b1;
            idx_d      = 4'd0;
          end else begin
            idx_d   = 4'd1;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = 4'd0;
        end else if (handshake) begin
          if (idx_q == LAST_IDX && s_last) begin
            activeLoad    = 1'b1;
            commitPulse_d = 1'b1;
            state_d       = COMMIT;
            idx_d         = 4'd0;
          end else if (idx_q == LAST_IDX || s_last) begin
            frameErr_d = 1'b1;
            state_d    = IDLE;
            idx_d      = 4'd0;
          end else begin
            shadowWe = 1'b1;
            idx_d    = idx_q + 4'd1;
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
        idx_d   = 4'd0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = 4'd0;
      end
    endcase
  end

  // Set has priority over clear so an overflow in the clearing cycle is not lost.
  always_comb begin
    ovf_d = ovf_q;
    if (overflow_any) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= 4'd0;
      commitPulse_q <= 1'b0;
      frameErr_q    <= 1'b0;
      commitCount_q <= 8'd0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      commitPulse_q <= commitPulse_d;
      frameErr_q    <= frameErr_d;
      ovf_q         <= ovf_d;
      if (activeLoad) begin
        commitCount_q <= commitCount_q + 8'd1;
      end
    end
  end

  // Shadow bank: the incoming word lands in the slot selected by idx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_COEFFS - 1; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_COEFFS - 1; k++) begin
        if (shadowWe && idx_q == 4'(k)) begin
          shadow_q[k] <= s_data;
        end
      end
    end
  end

  // Active bank: resets to a unity passthrough (b0 = 1.0, everything else 0
  // in every section) and is replaced wholesale on a good frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_COEFFS; k++) begin
        active_q[k] <= ((k % COEFFS_PER_SECTION) == B0) ? UNITY : '0;
      end
    end else if (activeLoad) begin
      for (int k = 0; k < NUM_COEFFS - 1; k++) begin
        active_q[k] <= shadow_q[k];
      end
      active_q[NUM_COEFFS-1] <= s_data;
    end
  end

  for (genvar g = 0; g < NUM_COEFFS; g++) begin : gen_flat
    assign coeff_flat[g*COEFF_WIDTH +: COEFF_WIDTH] = active_q[g];
  end

  assign commit_pulse = commitPulse_q;
  assign frame_err    = frameErr_q;
  assign commit_count = commitCount_q;
  assign ovf_sticky   = ovf_q;

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Self-checking bench for iir_coeff_loader.
//
// A table of frame records (length, position of s_last, optional abort
// point, data base, idle gaps, expected outcome) drives the main checks;
// hand-written sequences cover reset, the sticky overflow flag, commit
// counter wrap and reset in the middle of a frame.
module tb_iir_coeff_loader;

  localparam int W = 32;
  localparam int N = 15;

  logic             clk;
  logic             rst_n;
  logic             s_valid;
  logic             s_ready;
  logic [W-1:0]     s_data;
  logic             s_last;
  logic             abort;
  logic [N*W-1:0]   coeff_flat;
  logic             commit_pulse;
  logic             frame_err;
  logic [7:0]       commit_count;
  logic             overflow_any;
  logic             ovf_clr;
  logic             ovf_sticky;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] expBank [N];
  logic [7:0]   expCount;

  typedef struct {
    int          nWords;
    int          lastAt;
    int          abortAt;
    logic [31:0] base;
    bit          gaps;
    bit          expCommit;
    bit          expErr;
  } vec_t;

  vec_t vecs [9];

  iir_coeff_loader #(
    .COEFF_WIDTH (32),
    .SCALE_SHIFT (20)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .abort        (abort),
    .coeff_flat   (coeff_flat),
    .commit_pulse (commit_pulse),
    .frame_err    (frame_err),
    .commit_count (commit_count),
    .overflow_any (overflow_any),
    .ovf_clr      (ovf_clr),
    .ovf_sticky   (ovf_sticky)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something stalls the flow
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog act=running exp=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic checkBank(input string prefix);
    for (int k = 0; k < N; k++) begin
      checkOutput($sformatf("%s_w%0d", prefix, k), 64'(coeff_flat[k*W +: W]), 64'(expBank[k]));
    end
  endtask

  task automatic setUnity();
    for (int k = 0; k < N; k++) begin
      expBank[k] = (k % 5 == 0) ? 32'h0010_0000 : 32'h0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until it is accepted (bounded wait).
  task automatic sendWord(input logic [W-1:0] d, input logic l);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    n = 0;
    while (!s_ready && n < 8) begin
      tick();
      n++;
    end
    if (!s_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL ready_timeout act=0 exp=1");
    end
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Run one table record and check the outcome.
  task automatic applyStimulus(input vec_t v, input int vi);
    logic [W-1:0] newBank [N];
    logic [W-1:0] w;
    for (int k = 0; k < N; k++) begin
      newBank[k] = v.base + 32'(k);
    end
    for (int i = 0; i < v.nWords; i++) begin
      if (v.gaps) begin
        repeat ($urandom_range(0, 3)) tick();
      end
      w = v.base + 32'(i);
      if (i == v.abortAt) begin
        s_valid = 1'b1;
        s_data  = w;
        abort   = 1'b1;
        tick();
        s_valid = 1'b0;
        abort   = 1'b0;
        checkOutput($sformatf("v%0d_abort_err", vi), 64'(frame_err), 64'd0);
        checkOutput($sformatf("v%0d_abort_pulse", vi), 64'(commit_pulse), 64'd0);
        tick();
        checkOutput($sformatf("v%0d_abort_err2", vi), 64'(frame_err), 64'd0);
        checkBank($sformatf("v%0d_abort", vi));
        return;
      end
      if (i == v.nWords - 1 && v.expCommit) begin
        checkBank($sformatf("v%0d_prefinal", vi));
      end
      sendWord(w, (i == v.lastAt));
      if (i < v.nWords - 1) begin
        checkOutput($sformatf("v%0d_quiet%0d", vi, i), 64'({frame_err, commit_pulse}), 64'd0);
      end
    end
    if (v.expCommit) begin
      for (int k = 0; k < N; k++) expBank[k] = newBank[k];
      expCount = expCount + 8'd1;
      checkOutput($sformatf("v%0d_commit_pulse", vi), 64'(commit_pulse), 64'd1);
      checkOutput($sformatf("v%0d_commit_ready", vi), 64'(s_ready), 64'd0);
      checkOutput($sformatf("v%0d_commit_err", vi), 64'(frame_err), 64'd0);
      checkOutput($sformatf("v%0d_count", vi), 64'(commit_count), 64'(expCount));
      checkBank($sformatf("v%0d_commit", vi));
      tick();
      checkOutput($sformatf("v%0d_pulse_end", vi), 64'(commit_pulse), 64'd0);
      checkOutput($sformatf("v%0d_ready_back", vi), 64'(s_ready), 64'd1);
    end else if (v.expErr) begin
      checkOutput($sformatf("v%0d_err_pulse", vi), 64'(frame_err), 64'd1);
      checkOutput($sformatf("v%0d_err_commit", vi), 64'(commit_pulse), 64'd0);
      checkOutput($sformatf("v%0d_err_ready", vi), 64'(s_ready), 64'd1);
      checkOutput($sformatf("v%0d_err_count", vi), 64'(commit_count), 64'(expCount));
      checkBank($sformatf("v%0d_err", vi));
      tick();
      checkOutput($sformatf("v%0d_err_end", vi), 64'(frame_err), 64'd0);
    end
  endtask

  // Unchecked good frame, used to spin the commit counter.
  task automatic fastFrame(input logic [31:0] base);
    for (int i = 0; i < N; i++) begin
      sendWord(base + 32'(i), (i == N - 1));
    end
    for (int k = 0; k < N; k++) expBank[k] = base + 32'(k);
    expCount = expCount + 8'd1;
    tick();
  endtask

  initial begin
    //            nWords lastAt abortAt base           gaps commit err
    vecs[0] = '{15,  14,  -1, 32'h0000_0001, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{15,  14,  -1, 32'h0000_0100, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{ 7,   6,  -1, 32'h0000_0200, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{15,  14,  -1, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{15,  14,   8, 32'h0000_0300, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{15,  14,  -1, 32'h0000_0400, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{ 1,   0,  -1, 32'h0000_0500, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{15,  -1,  -1, 32'h0000_0600, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{15,  14,  -1, 32'h8000_0000, 1'b0, 1'b1, 1'b0};

    rst_n        = 1'b0;
    s_valid      = 1'b0;
    s_data       = '0;
    s_last       = 1'b0;
    abort        = 1'b0;
    overflow_any = 1'b0;
    ovf_clr      = 1'b0;
    expCount     = 8'd0;
    setUnity();

    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    checkBank("reset");
    checkOutput("reset_ready", 64'(s_ready), 64'd1);
    checkOutput("reset_ovf", 64'(ovf_sticky), 64'd0);
    checkOutput("reset_count", 64'(commit_count), 64'd0);
    checkOutput("reset_pulses", 64'({commit_pulse, frame_err}), 64'd0);

    for (int v = 0; v < 9; v++) begin
      applyStimulus(vecs[v], v);
    end

    // Sticky overflow: set, survive a simultaneous clear, then clear alone
    overflow_any = 1'b1;
    tick();
    overflow_any = 1'b0;
    checkOutput("ovf_set", 64'(ovf_sticky), 64'd1);
    tick();
    checkOutput("ovf_hold", 64'(ovf_sticky), 64'd1);
    overflow_any = 1'b1;
    ovf_clr      = 1'b1;
    tick();
    overflow_any = 1'b0;
    checkOutput("ovf_set_wins", 64'(ovf_sticky), 64'd1);
    tick();
    ovf_clr = 1'b0;
    checkOutput("ovf_cleared", 64'(ovf_sticky), 64'd0);

    // Spin the commit counter to 255, then one more frame wraps it to 0
    while (expCount != 8'd255) begin
      fastFrame(32'h1000_0000 + 32'(expCount));
    end
    checkOutput("count_255", 64'(commit_count), 64'd255);
    fastFrame(32'h2000_0000);
    checkOutput("count_wrap", 64'(commit_count), 64'd0);
    checkBank("wrap_bank");

    // Reset in the middle of a frame returns the active bank to unity
    for (int i = 0; i < 5; i++) begin
      sendWord(32'h3000_0000 + 32'(i), 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    setUnity();
    expCount = 8'd0;
    checkBank("midrst");
    checkOutput("midrst_count", 64'(commit_count), 64'd0);
    checkOutput("midrst_ready", 64'(s_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    applyStimulus(vecs[0], 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
